// File: rtl/register_1_if.sv
// rtl/register_1_if.sv - write/read port bundle for the 8x8 register file
interface register_1_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] OR2;
    logic [DATA_W-1:0] ALU_IN;
    logic [2:0]        mux_sel;
    logic [ADDR_W-1:0] reg_sel;
    logic [1:0]        enab;
    logic [ADDR_W-1:0] seg;
    logic [DATA_W-1:0] dataout_A;
    logic [DATA_W-1:0] dataout_B;

    modport master (
        output OR2, ALU_IN, mux_sel, reg_sel, enab, seg,
        input  dataout_A, dataout_B
    );

    modport slave (
        input  OR2, ALU_IN, mux_sel, reg_sel, enab, seg,
        output dataout_A, dataout_B
    );
endinterface

// File: rtl/register_1.sv
// rtl/register_1.sv - 8x8 register file, one muxed write port, two registered read ports
module register_1 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic         clk,
    input  logic         rst,
    register_1_if.slave  bus
);
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] data_a_q;
    logic [DATA_W-1:0] data_b_q;
    logic [DATA_W-1:0] wdata;
    logic              wsrc_valid;
    logic              write_op;
    logic              read_op;

    // Unknown enab never matches an operation code, so it falls through to idle.
    always_comb begin
        write_op = 1'b0;
        read_op  = 1'b0;
        case (bus.enab)
            OP_WRITE: write_op = 1'b1;
            OP_READ:  read_op  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wdata      = '0;
        wsrc_valid = 1'b0;
        case (bus.mux_sel)
            3'b001: begin
                wdata      = regs[bus.reg_sel];
                wsrc_valid = 1'b1;
            end
            3'b010: begin
                wdata      = bus.OR2;
                wsrc_valid = 1'b1;
            end
            3'b011: begin
                wdata      = bus.ALU_IN;
                wsrc_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            if (write_op && wsrc_valid) begin
                regs[bus.seg] <= wdata;
            end
            if (read_op) begin
                data_a_q <= regs[bus.seg];
                data_b_q <= regs[bus.reg_sel];
            end
        end
    end

    assign bus.dataout_A = data_a_q;
    assign bus.dataout_B = data_b_q;
endmodule

// File: tb/tb_register_1.sv
// tb/tb_register_1.sv - directed self-checking bench for register_1
module tb_register_1;
    logic clk;
    logic rst;
    logic clk_run;
    int   errors;
    int   checks;

    register_1_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    register_1 #(.DATA_W(8), .NREGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic op_cycle(input logic [1:0] enab, input logic [2:0] mux_sel,
                            input logic [2:0] seg, input logic [2:0] reg_sel,
                            input logic [7:0] or2, input logic [7:0] alu);
        @(negedge clk);
        bus.enab    = enab;
        bus.mux_sel = mux_sel;
        bus.seg     = seg;
        bus.reg_sel = reg_sel;
        bus.OR2     = or2;
        bus.ALU_IN  = alu;
        @(posedge clk);
        #1;
        bus.enab = 2'b00;
    endtask

    task automatic do_read(input string tag, input logic [2:0] seg, input logic [2:0] reg_sel,
                           input logic [7:0] exp_a, input logic [7:0] exp_b);
        op_cycle(2'b11, 3'b000, seg, reg_sel, 8'h00, 8'h00);
        check({tag, "_A"}, bus.dataout_A, exp_a);
        check({tag, "_B"}, bus.dataout_B, exp_b);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        clk_run     = 1'b0;
        rst         = 1'b0;
        bus.enab    = 2'b00;
        bus.mux_sel = 3'b000;
        bus.seg     = 3'd0;
        bus.reg_sel = 3'd0;
        bus.OR2     = 8'h00;
        bus.ALU_IN  = 8'h00;

        // Reset with the clock stopped must clear outputs immediately.
        #1 rst = 1'b1;
        #2;
        check("rst_idle_A", bus.dataout_A, 8'h00);
        check("rst_idle_B", bus.dataout_B, 8'h00);
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_read("rd_r7", 3'd7, 3'd7, 8'h00, 8'h00);

        // Write OR2 into R2; outputs hold through the write.
        op_cycle(2'b01, 3'b010, 3'd2, 3'd0, 8'h05, 8'h00);
        check("wr_hold_A", bus.dataout_A, 8'h00);
        do_read("rd_r2", 3'd2, 3'd2, 8'h05, 8'h05);

        // Move R2 -> R0.
        op_cycle(2'b01, 3'b001, 3'd0, 3'd2, 8'h00, 8'h00);
        do_read("rd_mov", 3'd0, 3'd2, 8'h05, 8'h05);

        // ALU result into R0.
        op_cycle(2'b01, 3'b011, 3'd0, 3'd2, 8'h00, 8'h07);
        check("wr_hold_B", bus.dataout_B, 8'h05);
        do_read("rd_alu", 3'd0, 3'd2, 8'h07, 8'h05);

        // Reserved write sources leave R0 untouched.
        op_cycle(2'b01, 3'b100, 3'd0, 3'd1, 8'hAA, 8'hAA);
        op_cycle(2'b01, 3'b000, 3'd0, 3'd1, 8'hBB, 8'hBB);
        op_cycle(2'b01, 3'b111, 3'd0, 3'd1, 8'hCC, 8'hCC);
        do_read("rd_rsv", 3'd0, 3'd2, 8'h07, 8'h05);

        // Idle encodings hold outputs even as addresses move.
        op_cycle(2'b00, 3'b010, 3'd5, 3'd6, 8'h11, 8'h22);
        check("idle00_A", bus.dataout_A, 8'h07);
        check("idle00_B", bus.dataout_B, 8'h05);
        op_cycle(2'b10, 3'b010, 3'd3, 3'd4, 8'h33, 8'h44);
        check("idle10_A", bus.dataout_A, 8'h07);
        check("idle10_B", bus.dataout_B, 8'h05);
        do_read("rd_idle", 3'd5, 3'd3, 8'h00, 8'h00);

        // Self-move keeps the value; all-ones data copies bit-exact.
        op_cycle(2'b01, 3'b010, 3'd5, 3'd0, 8'h3C, 8'h00);
        op_cycle(2'b01, 3'b001, 3'd5, 3'd5, 8'h00, 8'h00);
        op_cycle(2'b01, 3'b011, 3'd7, 3'd0, 8'h00, 8'hFF);
        do_read("rd_self", 3'd5, 3'd7, 8'h3C, 8'hFF);
        op_cycle(2'b01, 3'b001, 3'd1, 3'd7, 8'h00, 8'h00);
        do_read("rd_r1", 3'd1, 3'd0, 8'hFF, 8'h07);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("rst_async_A", bus.dataout_A, 8'h00);
        check("rst_async_B", bus.dataout_B, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        do_read("rst_r01", 3'd0, 3'd1, 8'h00, 8'h00);
        do_read("rst_r23", 3'd2, 3'd3, 8'h00, 8'h00);
        do_read("rst_r45", 3'd4, 3'd5, 8'h00, 8'h00);
        do_read("rst_r67", 3'd6, 3'd7, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
